// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared widths and request type for the barrel-shifter blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

  localparam int SHIFT_N  = 8;
  localparam int SHIFT_SW = 3;

  typedef struct packed {
    logic [SHIFT_N-1:0]  data;
    logic [SHIFT_SW-1:0] shamt;
  } shift_req_t;

endpackage
`default_nettype wire

// File: rtl/shift_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : shift_req_fifo
// Description : Circular-buffer FIFO with occupancy count and full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_req_fifo
  import shift_pkg::*;
#(
  parameter int W     = SHIFT_N + SHIFT_SW,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/shift_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : shift_req_queue
// Description : Request FIFO feeding an external combinational shifter, with a
//               registered back-pressured result. Optional SHIFT_REQ_BYPASS_EN
//               steers a request straight to the shifter when the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_req_queue
  import shift_pkg::*;
#(
  parameter int N     = SHIFT_N,
  parameter int SW    = SHIFT_SW,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            in_data,
  input  logic [SW-1:0]           in_shamt,
  output logic [N-1:0]            sh_data,
  output logic [SW-1:0]           sh_amt,
  input  logic [N-1:0]            sh_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            out_data,
  output logic [SW-1:0]           out_shamt,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int EW = N + SW;

  logic [EW-1:0] w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_out_free;
  logic          w_bypass;
  logic          w_avail;
  logic          w_load;
  logic          w_push;
  logic          w_pop;

  logic          r_out_valid;
  logic [N-1:0]  r_out_data;
  logic [SW-1:0] r_out_shamt;

  shift_req_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({in_data, in_shamt}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // in_ready depends on occupancy only; a same-cycle pop never frees a full slot.
  assign in_ready   = !w_full;
  assign w_accept   = in_valid && in_ready;
  assign w_out_free = !r_out_valid || out_ready;

`ifdef SHIFT_REQ_BYPASS_EN
  assign w_bypass = w_empty && in_valid && w_out_free;

  always_comb begin
    sh_data = '0;
    sh_amt  = '0;
    if (w_bypass) begin
      sh_data = in_data;
      sh_amt  = in_shamt;
    end else if (!w_empty) begin
      sh_data = w_head[EW-1:SW];
      sh_amt  = w_head[SW-1:0];
    end
  end
`else
  assign w_bypass = 1'b0;

  always_comb begin
    sh_data = '0;
    sh_amt  = '0;
    if (!w_empty) begin
      sh_data = w_head[EW-1:SW];
      sh_amt  = w_head[SW-1:0];
    end
  end
`endif

  assign w_avail = !w_empty || w_bypass;
  assign w_load  = w_avail && w_out_free;
  assign w_pop   = w_load && !w_empty;
  assign w_push  = w_accept && !w_bypass;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_shamt <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= sh_result;
      r_out_shamt <= sh_amt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_shamt = r_out_shamt;

endmodule
`default_nettype wire
